// File: rtl/forward_scoreboard.sv
// Execute-stage operand forwarding with a pending-write scoreboard for multi-cycle producers.
// Optional statistics counters are enabled with `define FORWARD_SCOREBOARD_STATS_EN.
module forward_scoreboard #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned MAX_LAT        = 15,
  localparam int unsigned CNT_W         = $clog2(MAX_LAT + 1),
  localparam int unsigned REG_W         = 5
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic                               issueValid,
  input  logic [REG_W-1:0]                   issueDest,
  input  logic [CNT_W-1:0]                   issueLat,
  input  logic [NUM_SRC*REG_W-1:0]           issueSrc,
  output logic                               issueFire,
  input  logic [NUM_FWD_STAGES-1:0]          stageValid,
  input  logic [NUM_FWD_STAGES*REG_W-1:0]    stageDest,
  input  logic [NUM_FWD_STAGES*XLEN-1:0]     stageData,
  input  logic [NUM_FWD_STAGES-1:0]          stageReady,
  input  logic                               commitValid,
  input  logic [REG_W-1:0]                   commitDest,
  output logic [NUM_SRC-1:0]                 fwdEnable,
  output logic [NUM_SRC*XLEN-1:0]            fwdData,
  output logic                               stall
`ifdef FORWARD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                        statStallCycles,
  output logic [31:0]                        statFwdHits
`endif
);

  // Bit 0 exists only so a source index can address the vector directly; it never sets.
  logic [31:0]          busy;
  logic [CNT_W-1:0]     cnt [31:1];
  logic [CNT_W-1:0]     lat_sat;

  logic [NUM_SRC-1:0]        fwd_en;
  logic [NUM_SRC*XLEN-1:0]   fwd_data;
  logic [NUM_SRC-1:0]        hazard;
  logic [REG_W-1:0]          src;
  logic                      matched;
  logic                      blocked;
  logic                      stall_int;
  logic                      fire_int;

  // Clamp oversized latencies; only reachable when MAX_LAT is not 2^n-1.
  if (MAX_LAT == (2 ** CNT_W) - 1) begin : g_lat_full
    assign lat_sat = issueLat;
  end else begin : g_lat_clamp
    assign lat_sat = (issueLat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issueLat;
  end

  // Youngest-first stage match per source; an unready younger match hides older stages.
  always_comb begin
    fwd_en   = '0;
    fwd_data = '0;
    hazard   = '0;
    src      = '0;
    matched  = 1'b0;
    blocked  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src     = issueSrc[s*REG_W +: REG_W];
      matched = 1'b0;
      blocked = 1'b0;
      for (int i = 0; i < NUM_FWD_STAGES; i++) begin
        if (!matched && (src != '0) && stageValid[i] &&
            (stageDest[i*REG_W +: REG_W] == src)) begin
          matched = 1'b1;
          if (stageReady[i]) begin
            fwd_en[s]                 = 1'b1;
            fwd_data[s*XLEN +: XLEN]  = stageData[i*XLEN +: XLEN];
          end else begin
            blocked = 1'b1;
          end
        end
      end
      hazard[s] = blocked || (busy[src] && !fwd_en[s]);
    end
  end

  assign stall_int = resetn && issueValid && (|hazard);
  assign fire_int  = resetn && issueValid && !stall_int;

  assign stall     = stall_int;
  assign issueFire = fire_int;
  assign fwdEnable = resetn ? fwd_en : '0;
  assign fwdData   = resetn ? fwd_data : '0;

  // Per-register update: issue set beats commit clear beats countdown; flush beats all.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
    end else if (flush) begin
      busy <= '0;
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (fire_int && (lat_sat != '0) && (issueDest == REG_W'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= lat_sat;
        end else if (commitValid && (commitDest == REG_W'(r))) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (busy[r]) begin
          cnt[r] <= (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
          if (cnt[r] <= CNT_W'(1)) busy[r] <= 1'b0;
        end
      end
    end
  end

`ifdef FORWARD_SCOREBOARD_STATS_EN
  localparam int unsigned POP_W = $clog2(NUM_SRC + 1);

  logic [POP_W-1:0] hit_pop;
  logic [32:0]      hit_sum;

  always_comb begin
    hit_pop = '0;
    for (int s = 0; s < NUM_SRC; s++) hit_pop = hit_pop + POP_W'(fwd_en[s]);
    hit_sum = {1'b0, statFwdHits} + 33'(hit_pop);
  end

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      statStallCycles <= '0;
      statFwdHits     <= '0;
    end else begin
      if (stall_int && (statStallCycles != '1)) statStallCycles <= statStallCycles + 32'd1;
      if (fire_int) statFwdHits <= hit_sum[32] ? '1 : hit_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard with default parameters.
module tb_forward_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        issueValid;
  logic [4:0]  issueDest;
  logic [3:0]  issueLat;
  logic [9:0]  issueSrc;
  logic        issueFire;
  logic [1:0]  stageValid;
  logic [9:0]  stageDest;
  logic [63:0] stageData;
  logic [1:0]  stageReady;
  logic        commitValid;
  logic [4:0]  commitDest;
  logic [1:0]  fwdEnable;
  logic [63:0] fwdData;
  logic        stall;
`ifdef FORWARD_SCOREBOARD_STATS_EN
  logic [31:0] statStallCycles;
  logic [31:0] statFwdHits;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  forward_scoreboard dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .issueValid  (issueValid),
    .issueDest   (issueDest),
    .issueLat    (issueLat),
    .issueSrc    (issueSrc),
    .issueFire   (issueFire),
    .stageValid  (stageValid),
    .stageDest   (stageDest),
    .stageData   (stageData),
    .stageReady  (stageReady),
    .commitValid (commitValid),
    .commitDest  (commitDest),
    .fwdEnable   (fwdEnable),
    .fwdData     (fwdData),
    .stall       (stall)
`ifdef FORWARD_SCOREBOARD_STATS_EN
    ,
    .statStallCycles (statStallCycles),
    .statFwdHits     (statFwdHits)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow after a further 1ns settle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    flush = 1'b0; issueValid = 1'b0; issueDest = '0; issueLat = '0; issueSrc = '0;
    stageValid = '0; stageDest = '0; stageData = '0; stageReady = '0;
    commitValid = 1'b0; commitDest = '0;
  endtask

  task automatic srcs(input logic [4:0] s0, input logic [4:0] s1);
    issueSrc = {s1, s0};
  endtask

  task automatic issue(input logic [4:0] d, input logic [3:0] lat, input logic [4:0] s0,
                       input logic [4:0] s1);
    issueValid = 1'b1; issueDest = d; issueLat = lat; srcs(s0, s1);
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    issueValid = 1'b1; srcs(5'd5, 5'd6);
    settle();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_fwden", 64'(fwdEnable), 64'd0);
    check("rst_fire", 64'(issueFire), 64'd0);
    check("rst_fwdata", fwdData, 64'd0);
    tick(); tick();
    resetn = 1'b1;
    settle();
    check("post_rst_stall", 64'(stall), 64'd0);
    check("post_rst_fire", 64'(issueFire), 64'd1);

    // Youngest stage wins when both stages write x5.
    stageValid = 2'b11; stageReady = 2'b11; stageDest = {5'd5, 5'd5};
    stageData = {32'h0000_1234, 32'hDEAD_BEEF};
    settle();
    check("fwd_young_en", 64'(fwdEnable), 64'b01);
    check("fwd_young_d0", 64'(fwdData[31:0]), 64'hDEAD_BEEF);
    check("fwd_young_d1", 64'(fwdData[63:32]), 64'd0);

    // Distinct stages feed both sources.
    stageDest = {5'd6, 5'd5}; stageData = {32'h0000_0055, 32'h0000_00AA};
    settle();
    check("fwd_both_en", 64'(fwdEnable), 64'b11);
    check("fwd_both_d", fwdData, {32'h55, 32'hAA});

    // Unready load in stage 0 blocks the ready older copy in stage 1.
    tick();
    issueValid = 1'b1; srcs(5'd7, 5'd6);
    stageValid = 2'b11; stageDest = {5'd7, 5'd7}; stageReady = 2'b10;
    stageData = {32'h0000_0777, 32'h0000_AAAA};
    settle();
    check("ld_block_stall", 64'(stall), 64'd1);
    check("ld_block_en", 64'(fwdEnable), 64'b00);
    check("ld_block_fire", 64'(issueFire), 64'd0);
    tick();
    stageReady = 2'b11;
    settle();
    check("ld_ready_stall", 64'(stall), 64'd0);
    check("ld_ready_en", 64'(fwdEnable), 64'b01);
    check("ld_ready_d0", 64'(fwdData[31:0]), 64'h0000_AAAA);

    // Latency 3 to x9: dependent stalls exactly three cycles.
    tick();
    idle();
    issue(5'd9, 4'd3, 5'd1, 5'd2);
    settle();
    check("lat_issue_fire", 64'(issueFire), 64'd1);
    tick();
    issue(5'd0, 4'd0, 5'd9, 5'd2);
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("lat3_stall_c%0d", k), 64'(stall), 64'd1);
      tick();
    end
    settle();
    check("lat3_release", 64'(stall), 64'd0);

    // Commit shortens the wait to the next edge.
    tick();
    issue(5'd9, 4'd3, 5'd1, 5'd2);
    tick();
    issue(5'd0, 4'd0, 5'd2, 5'd9);
    commitValid = 1'b1; commitDest = 5'd9;
    settle();
    check("commit_pre_stall", 64'(stall), 64'd1);
    tick();
    commitValid = 1'b0; commitDest = '0;
    settle();
    check("commit_post_stall", 64'(stall), 64'd0);

    // A ready forward overrides the busy bit; an unready one does not.
    tick();
    issue(5'd9, 4'd5, 5'd1, 5'd2);
    tick();
    issue(5'd0, 4'd0, 5'd9, 5'd2);
    stageValid = 2'b01; stageDest = {5'd0, 5'd9}; stageReady = 2'b01;
    stageData = {32'd0, 32'h0000_0999};
    settle();
    check("busy_fwd_stall", 64'(stall), 64'd0);
    check("busy_fwd_en", 64'(fwdEnable), 64'b01);
    stageReady = 2'b00;
    settle();
    check("busy_unready_stall", 64'(stall), 64'd1);
    commitValid = 1'b1; commitDest = 5'd9;
    tick();
    idle();

    // Same-cycle issue, commit and busy countdown on x9: the new latency 2 wins.
    issue(5'd9, 4'd4, 5'd1, 5'd2);
    tick();
    issue(5'd9, 4'd2, 5'd1, 5'd2);
    commitValid = 1'b1; commitDest = 5'd9;
    settle();
    check("prio_fire", 64'(issueFire), 64'd1);
    tick();
    idle();
    issue(5'd0, 4'd0, 5'd9, 5'd0);
    settle();
    check("prio_stall_c0", 64'(stall), 64'd1);
    tick();
    settle();
    check("prio_stall_c1", 64'(stall), 64'd1);
    tick();
    settle();
    check("prio_release", 64'(stall), 64'd0);

    // Flush clears busy x3/x4 and drops the issue to x10 made in the flush cycle.
    tick();
    issue(5'd3, 4'd5, 5'd1, 5'd2);
    tick();
    issue(5'd4, 4'd6, 5'd1, 5'd2);
    tick();
    issue(5'd0, 4'd0, 5'd3, 5'd4);
    settle();
    check("flush_pre_stall", 64'(stall), 64'd1);
    issue(5'd10, 4'd5, 5'd1, 5'd2);
    flush = 1'b1;
    settle();
    check("flush_cycle_fire", 64'(issueFire), 64'd1);
    tick();
    flush = 1'b0;
    issue(5'd0, 4'd0, 5'd3, 5'd4);
    settle();
    check("flush_x3x4_stall", 64'(stall), 64'd0);
    srcs(5'd10, 5'd1);
    settle();
    check("flush_x10_stall", 64'(stall), 64'd0);

    // x0 is never forwarded, busy or stalled.
    tick();
    issue(5'd0, 4'd5, 5'd0, 5'd0);
    stageValid = 2'b11; stageDest = {5'd0, 5'd0}; stageReady = 2'b10;
    stageData = {32'h1111_1111, 32'h2222_2222};
    settle();
    check("x0_stall", 64'(stall), 64'd0);
    check("x0_fwd_en", 64'(fwdEnable), 64'b00);
    check("x0_fwd_d", fwdData, 64'd0);
    tick();
    settle();
    check("x0_no_busy", 64'(stall), 64'd0);

    // Asynchronous reset mid-countdown discards the pending entry.
    idle();
    issue(5'd11, 4'd8, 5'd1, 5'd2);
    tick();
    issue(5'd0, 4'd0, 5'd11, 5'd0);
    settle();
    check("midrst_pre_stall", 64'(stall), 64'd1);
    #2 resetn = 1'b0;
    settle();
    check("midrst_in_stall", 64'(stall), 64'd0);
    check("midrst_in_fire", 64'(issueFire), 64'd0);
    tick();
    resetn = 1'b1;
    settle();
    check("midrst_post_stall", 64'(stall), 64'd0);
    check("midrst_post_fire", 64'(issueFire), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the combinational execute-stage forwarding mux.
- Adds a per-register pending-write scoreboard for multi-cycle producers (loads, mul/div). Raises `stall` when a source operand is pending and no forwarding stage holds ready data.
- Forwards from NUM_FWD_STAGES pipeline stages with youngest-first priority, for NUM_SRC source operands.
- Sits beside the decode/execute boundary. The hazard controller consumes `stall`; the operand muxes consume the forward outputs.

Parameters:
- XLEN, 32, data width.
- NUM_SRC, 2, source operands checked per issue (2 or 3).
- NUM_FWD_STAGES, 2, forwarding stages; index 0 is the youngest (execute/memory).
- MAX_LAT, 15, largest issue latency in cycles; counter width is $clog2(MAX_LAT+1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  clears all scoreboard state next edge.
- issueValid  in  1  instruction in decode wants to issue.
- issueDest  in  5  destination of the issuing instruction.
- issueLat  in  $clog2(MAX_LAT+1)  cycles until the result is forwardable; 0 = single-cycle, not tracked.
- issueSrc  in  NUM_SRC*5  packed source register indices.
- issueFire  out  1  issueValid && !stall; scoreboard updates only on fire.
- stageValid  in  NUM_FWD_STAGES  stage holds a valid writing instruction.
- stageDest  in  NUM_FWD_STAGES*5  stage destination registers.
- stageData  in  NUM_FWD_STAGES*XLEN  stage result data.
- stageReady  in  NUM_FWD_STAGES  stage data is final; 0 for a load still in the memory stage.
- commitValid  in  1  writeback retiring a register write.
- commitDest  in  5  register being written back.
- fwdEnable  out  NUM_SRC  per-source forward select.
- fwdData  out  NUM_SRC*XLEN  per-source forward data.
- stall  out  1  hold decode this cycle.

Behaviour:
- State is `busy[31:1]` plus a counter `cnt[r]` per register. x0 is never busy, forwarded or stalled.
- Reset (resetn low, async) clears all busy bits and counters to 0. While in reset, outputs are stall=0, fwdEnable=0, fwdData=0, issueFire=0. Reset mid-countdown discards all pending entries.
- Forward, combinational, per source s with index r != 0:
  - Scan stages 0..NUM_FWD_STAGES-1; the first stage i with stageValid[i] and stageDest[i]==r matches.
  - If stageReady[i]=1: fwdEnable[s]=1 and fwdData[s]=stageData[i].
  - If stageReady[i]=0: fwdEnable[s]=0 and the source is "blocked". An older stage is never used past a younger unready match.
  - With no match, fwdEnable=0 and fwdData=0.
- Stall, combinational: stall=1 when issueValid and any source s meets either condition:
  - the source is blocked, or
  - busy[r] is set and no ready stage match exists.
- Scoreboard update, rising edge:
  - Every busy counter decrements by 1. When it reaches 0, busy clears on that same edge.
  - commitValid with commitDest!=0 clears busy and cnt for that register.
  - issueFire with issueLat>0 and issueDest!=0 sets busy=1 and cnt=issueLat.
  - Priority on the same register in the same cycle: issue set > commit clear > decrement.
  - issueLat>MAX_LAT saturates to MAX_LAT.
  - flush clears everything and overrides all updates in that cycle. An issue that fires in the flush cycle is discarded.
- Latency: a register set busy at edge N with issueLat=L first reads not-busy in the cycle after edge N+L, unless committed earlier.
- Stall does not modify state. Counters continue to decrement while stalled.

Optional Feature:
- Macro: FORWARD_SCOREBOARD_STATS_EN.
- When defined, adds two output ports, each 32 bits, saturating, reset to 0:
  - statStallCycles: +1 per cycle with stall=1.
  - statFwdHits: +popcount(fwdEnable) per cycle with issueFire=1.
- Both counters clear on reset only, not on flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with issueValid=1, issueSrc={x5,x6}, no stages valid → stall=0, fwdEnable=00, busy all 0.
- Stage0 valid, dest x5, ready, data 0xDEADBEEF; stage1 valid, dest x5, data 0x1234 → fwdData[0]=0xDEADBEEF, fwdEnable=01.
- Stage0 holds a load to x7 with stageReady=0, stage1 holds x7 ready; issue src x7 → stall=1, fwdEnable[0]=0. Next cycle stageReady=1 → stall=0, forwarded.
- Issue dest x9 with issueLat=3; next instruction reads x9 → stall=1 for exactly 3 cycles, then 0. Repeat with commitValid x9 after 1 cycle → stall drops after that edge.
- Issue dest x9 with lat=4, commit x9, and a new issue to x9 with lat=2, all in one cycle → busy[x9]=1, cnt=2.
- flush pulsed while x3 and x4 are busy → both clear next edge. Sources x0 and x0 → never stall, fwdEnable=00 even with stage dest x0 valid.
